// File: rtl/affine_addr_gen.sv
// Affine loop-nest address generator: walks a DIMS-deep odometer and emits
// offset + sum(count[d]*stride[d]) per valid/ready transfer.

module affine_addr_gen_dim #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] cfg_ext,
  input  logic [WIDTH-1:0] cfg_stride,
  output logic             wrap,
  output logic [WIDTH-1:0] acc_nx
);
  logic [WIDTH-1:0] ext_m1, stride, count, acc;

  assign wrap = (count == ext_m1);

  // acc tracks count*stride incrementally so no multiplier is needed
  always_comb begin
    acc_nx = acc;
    if (inc) acc_nx = wrap ? '0 : acc + stride;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_m1 <= '0;
      stride <= '0;
      count  <= '0;
      acc    <= '0;
    end else if (load) begin
      // extent 0 behaves as extent 1
      ext_m1 <= (cfg_ext == '0) ? '0 : cfg_ext - WIDTH'(1);
      stride <= cfg_stride;
      count  <= '0;
      acc    <= '0;
    end else if (clr) begin
      count  <= '0;
      acc    <= '0;
    end else if (inc) begin
      count  <= wrap ? '0 : count + WIDTH'(1);
      acc    <= acc_nx;
    end
  end
endmodule

module affine_addr_gen #(
  parameter int WIDTH = 16,
  parameter int DIMS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      cfg_offset,
  input  logic [DIMS*WIDTH-1:0] cfg_extent,
  input  logic [DIMS*WIDTH-1:0] cfg_stride,
  output logic [WIDTH-1:0]      addr_out,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic                        run, launch, kill, adv;
  logic [DIMS-1:0]             chain, wrap;
  logic [DIMS-1:0][WIDTH-1:0]  acc_nx;
  logic [WIDTH-1:0]            offset_q, acc_sum;

  assign run        = (state_q == RUN);
  assign launch     = !run && start && !abort;
  assign kill       = run && abort;
  assign adv        = run && addr_ready && !abort;
  assign addr_valid = run;
  assign busy       = run;
  assign addr_last  = run && (&wrap);

  genvar d;
  generate
    for (d = 0; d < DIMS; d++) begin : g_dim
      if (d == 0) begin : g_c0
        assign chain[d] = adv;
      end else begin : g_cn
        assign chain[d] = chain[d-1] && wrap[d-1];
      end
      affine_addr_gen_dim #(.WIDTH(WIDTH)) u_dim (
        .clk        (clk),
        .rst        (rst),
        .load       (launch),
        .clr        (kill),
        .inc        (chain[d]),
        .cfg_ext    (cfg_extent[d*WIDTH +: WIDTH]),
        .cfg_stride (cfg_stride[d*WIDTH +: WIDTH]),
        .wrap       (wrap[d]),
        .acc_nx     (acc_nx[d])
      );
    end
  endgenerate

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < DIMS; i++) acc_sum = acc_sum + acc_nx[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (launch) state_d = RUN;
      RUN:  if (kill || (adv && addr_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // On the final transfer the odometer wraps to zero; addr_out keeps the last address
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      addr_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= adv && addr_last;
      if (launch) begin
        offset_q <= cfg_offset;
        addr_out <= cfg_offset;
      end else if (adv && !addr_last) begin
        addr_out <= offset_q + acc_sum;
      end
    end
  end
endmodule

// File: tb/tb_affine_addr_gen.sv
// Self-checking bench for affine_addr_gen: randomized backpressure and configs
// checked against an index-enumeration reference model.
module tb_affine_addr_gen;
  localparam int W = 16;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           rst, start, abort, addr_ready;
  logic [W-1:0]   cfg_offset;
  logic [D*W-1:0] cfg_extent, cfg_stride;
  logic [W-1:0]   addr_out;
  logic           addr_valid, addr_last, busy, done;

  affine_addr_gen #(.WIDTH(W), .DIMS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_offset(cfg_offset), .cfg_extent(cfg_extent), .cfg_stride(cfg_stride),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_last(addr_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [W-1:0] m_off;
  logic [W-1:0] m_ext[D];
  logic [W-1:0] m_str[D];
  logic [W-1:0] exp_addr[$];
  logic         exp_last[$];
  logic [W-1:0] obs_addr[$];
  logic         obs_last[$];
  int  stall_err, extra_done, cyc;
  bit  timeout;

  // Enumerate every index tuple (dimension 0 fastest) and compute the address directly
  task automatic build_model();
    longint e[D];
    longint total, r, a, idx;
    exp_addr.delete(); exp_last.delete();
    total = 1;
    for (int i = 0; i < D; i++) begin
      e[i] = (m_ext[i] == 0) ? 1 : longint'(m_ext[i]);
      total = total * e[i];
    end
    for (longint n = 0; n < total; n++) begin
      r = n; a = longint'(m_off);
      for (int i = 0; i < D; i++) begin
        idx = r % e[i]; r = r / e[i];
        a = a + idx * longint'(m_str[i]);
      end
      exp_addr.push_back(W'(a));
      exp_last.push_back(n == total - 1);
    end
  endtask

  task automatic launch();
    cfg_offset = m_off;
    for (int i = 0; i < D; i++) begin
      cfg_extent[i*W +: W] = m_ext[i];
      cfg_stride[i*W +: W] = m_str[i];
    end
    start = 1'b1;
    build_model();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_cfg(input logic [W-1:0] off, input logic [W-1:0] e0, e1, e2,
                         input logic [W-1:0] s0, s1, s2);
    m_off = off;
    m_ext[0] = e0; m_ext[1] = e1; m_ext[2] = e2;
    m_str[0] = s0; m_str[1] = s1; m_str[2] = s2;
  endtask

  task automatic rand_cfg();
    m_off = W'($urandom);
    for (int i = 0; i < D; i++) begin
      m_ext[i] = W'($urandom_range(0, 3));
      m_str[i] = W'($urandom);
    end
  endtask

  // Observe transfers until the last one; ready_pct<0 selects the 1,0,0 pattern.
  // perturb_at pulses start and scrambles the config inputs on that cycle.
  task automatic collect(input int ready_pct, input int perturb_at);
    logic [W-1:0] held_a;
    logic held_l, held_v, fin;
    obs_addr.delete(); obs_last.delete();
    stall_err = 0; extra_done = 0; timeout = 0; cyc = 0; fin = 0;
    while (!fin) begin
      if (cyc >= 2000) begin timeout = 1; break; end
      addr_ready = (ready_pct < 0) ? (cyc % 3 == 0) : ($urandom_range(99) < ready_pct);
      if (cyc == perturb_at) begin
        start = 1'b1;
        cfg_offset = W'($urandom); cfg_stride = {D{W'($urandom)}}; cfg_extent = {D{W'($urandom)}};
      end else start = 1'b0;
      if (done) extra_done++;
      if (addr_valid && addr_ready) begin
        obs_addr.push_back(addr_out); obs_last.push_back(addr_last);
        if (addr_last) fin = 1;
      end
      held_a = addr_out; held_l = addr_last; held_v = addr_valid && !addr_ready;
      @(posedge clk); #1;
      cyc++;
      if (held_v && addr_valid && (addr_out !== held_a || addr_last !== held_l)) stall_err++;
    end
    start = 1'b0; addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; addr_ready = 1'b1;
    set_cfg(16'h1234, 2, 2, 2, 1, 1, 1);
    cfg_offset = m_off; cfg_extent = '1; cfg_stride = '1;
    repeat (2) @(posedge clk); #1;
    n_total++;
    if (addr_out !== '0 || addr_valid !== 0 || addr_last !== 0 || busy !== 0 || done !== 0)
      $display("FAIL reset outputs got addr=%h v=%b l=%b busy=%b done=%b want all 0",
               addr_out, addr_valid, addr_last, busy, done);
    else n_pass++;
    rst = 1'b0; start = 1'b0; addr_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_2d_full_rate();
    set_cfg(100, 3, 2, 1, 1, 10, 0);
    launch();
    n_total++;
    if (addr_valid !== 1 || busy !== 1 || addr_out !== 16'd100)
      $display("FAIL 2d_first got v=%b busy=%b addr=%0d want 1/1/100", addr_valid, busy, addr_out);
    else n_pass++;
    collect(100, -1);
    n_total++;
    if (cyc != 6 || obs_addr.size() != 6 || timeout)
      $display("FAIL 2d_full count got cycles=%0d xfers=%0d want 6/6", cyc, obs_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_total++;
      if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
        $display("FAIL 2d_full[%0d] got %0d/%b want %0d/%b", i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
      else n_pass++;
    end
    n_total++;
    if (done !== 1 || busy !== 0 || addr_valid !== 0 || addr_last !== 0 || addr_out !== exp_addr[$] || extra_done != 0)
      $display("FAIL 2d_full_end got done=%b busy=%b v=%b l=%b addr=%0d xdone=%0d want 1/0/0/0/%0d/0",
               done, busy, addr_valid, addr_last, addr_out, extra_done, exp_addr[$]);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 0) $display("FAIL done_width got done=%b want 0", done);
    else n_pass++;
  endtask

  task automatic test_2d_backpressure();
    set_cfg(100, 3, 2, 1, 1, 10, 0);
    launch();
    collect(-1, -1);
    n_total++;
    if (obs_addr.size() != exp_addr.size() || timeout || stall_err != 0)
      $display("FAIL 2d_bp got xfers=%0d stall_err=%0d want %0d/0", obs_addr.size(), stall_err, exp_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_total++;
      if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
        $display("FAIL 2d_bp[%0d] got %0d/%b want %0d/%b", i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
      else n_pass++;
    end
    n_total++;
    if (done !== 1 || busy !== 0 || extra_done != 0)
      $display("FAIL 2d_bp_end got done=%b busy=%b xdone=%0d want 1/0/0", done, busy, extra_done);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_extent_and_wrap();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_cfg(0, 2, 0, 2, 4, 7, 100);
      else        set_cfg(16'hFFFE, 4, 1, 1, 1, 0, 0);
      launch();
      collect(70, -1);
      n_total++;
      if (obs_addr.size() != 4 || timeout)
        $display("FAIL edge%0d count got %0d want 4", t, obs_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        n_total++;
        if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
          $display("FAIL edge%0d[%0d] got %h/%b want %h/%b", t, i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
        else n_pass++;
      end
      n_total++;
      if (done !== 1 || busy !== 0 || stall_err != 0)
        $display("FAIL edge%0d_end got done=%b busy=%b stall=%0d want 1/0/0", t, done, busy, stall_err);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    set_cfg(500, 4, 3, 1, 3, 50, 9);
    launch();
    addr_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; addr_ready = 1'b0;
    n_total++;
    if (addr_valid !== 0 || busy !== 0 || done !== 0)
      $display("FAIL abort_mid got v=%b busy=%b done=%b want 0/0/0", addr_valid, busy, done);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 0 || busy !== 0) $display("FAIL abort_nodone got done=%b busy=%b want 0/0", done, busy);
    else n_pass++;
    launch();
    n_total++;
    if (addr_out !== 16'd500 || addr_valid !== 1)
      $display("FAIL abort_restart got addr=%0d v=%b want 500/1", addr_out, addr_valid);
    else n_pass++;
    collect(50, -1);
    n_total++;
    if (obs_addr.size() != exp_addr.size() || timeout)
      $display("FAIL abort_rerun count got %0d want %0d", obs_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_total++;
      if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
        $display("FAIL abort_rerun[%0d] got %0d/%b want %0d/%b", i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
    // single-address nest, aborted on its final transfer
    set_cfg(16'h0ABC, 1, 0, 1, 5, 6, 7);
    launch();
    n_total++;
    if (addr_out !== 16'h0ABC || addr_last !== 1)
      $display("FAIL single got addr=%h last=%b want 0abc/1", addr_out, addr_last);
    else n_pass++;
    addr_ready = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    addr_ready = 1'b0;
    n_total++;
    if (done !== 0 || busy !== 0) $display("FAIL abort_last got done=%b busy=%b want 0/0", done, busy);
    else n_pass++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_total++;
    if (busy !== 0 || addr_valid !== 0) $display("FAIL abort_idle got busy=%b v=%b want 0/0", busy, addr_valid);
    else n_pass++;
  endtask

  task automatic test_rst_mid_run();
    set_cfg(300, 3, 3, 2, 2, 20, 200);
    launch();
    addr_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; addr_ready = 1'b0;
    n_total++;
    if (addr_out !== '0 || addr_valid !== 0 || busy !== 0 || done !== 0)
      $display("FAIL rst_mid got addr=%0d v=%b busy=%b done=%b want 0/0/0/0", addr_out, addr_valid, busy, done);
    else n_pass++;
    launch();
    collect(100, -1);
    n_total++;
    if (obs_addr.size() != 18 || timeout) $display("FAIL rst_rerun count got %0d want 18", obs_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_total++;
      if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
        $display("FAIL rst_rerun[%0d] got %0d/%b want %0d/%b", i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    set_cfg(1000, 3, 2, 2, 1, 5, 40);
    launch();
    collect(60, 2);
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_total++;
      if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
        $display("FAIL b2b_a[%0d] got %0d/%b want %0d/%b", i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
      else n_pass++;
    end
    n_total++;
    if (obs_addr.size() != 12 || timeout || done !== 1)
      $display("FAIL b2b_a_end got xfers=%0d done=%b want 12/1", obs_addr.size(), done);
    else n_pass++;
    set_cfg(16'h2000, 2, 2, 0, 3, 30, 300);
    launch();
    n_total++;
    if (addr_out !== 16'h2000 || addr_valid !== 1 || done !== 0)
      $display("FAIL b2b_start got addr=%h v=%b done=%b want 2000/1/0", addr_out, addr_valid, done);
    else n_pass++;
    collect(100, -1);
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_total++;
      if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
        $display("FAIL b2b_b[%0d] got %h/%b want %h/%b", i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
      else n_pass++;
    end
    n_total++;
    if (obs_addr.size() != 4 || timeout) $display("FAIL b2b_b count got %0d want 4", obs_addr.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      rand_cfg();
      launch();
      collect(60, -1);
      n_total++;
      if (obs_addr.size() != exp_addr.size() || timeout || stall_err != 0 || extra_done != 0 || done !== 1)
        $display("FAIL rand%0d got xfers=%0d stall=%0d xdone=%0d done=%b want %0d/0/0/1",
                 r, obs_addr.size(), stall_err, extra_done, done, exp_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        n_total++;
        if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
          $display("FAIL rand%0d[%0d] got %h/%b want %h/%b", r, i, obs_addr[i], obs_last[i], exp_addr[i], exp_last[i]);
        else n_pass++;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    cfg_offset = '0; cfg_extent = '0; cfg_stride = '0;
    test_reset();
    test_2d_full_rate();
    test_2d_backpressure();
    test_zero_extent_and_wrap();
    test_abort();
    test_rst_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/affine_addr_gen.md
Name: affine_addr_gen

Overview:
- Parametrised successor to the fixed 2-level scan address generator.
- Walks a DIMS-deep loop nest with per-dimension extent and stride, plus a base offset.
- Emits one address per valid/ready transfer: addr = offset + sum(count[d]*stride[d]) mod 2^WIDTH.
- Adds what the 2-level generator lacks: start/done control, backpressure, last-flag, abort, and configuration latched per run.
- Sits between the controller and a memory read/write port.

Parameters:
- WIDTH, 16, bit width of addresses, extents, strides, offset and counters.
- DIMS, 3, number of loop dimensions; dimension 0 is innermost; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run; no done pulse.
- cfg_offset  in  WIDTH  base address.
- cfg_extent  in  DIMS*WIDTH  trip count per dimension; slice d is bits [d*WIDTH +: WIDTH].
- cfg_stride  in  DIMS*WIDTH  address increment per dimension; same slicing as cfg_extent.
- addr_out  out  WIDTH  current address; registered.
- addr_valid  out  1  addr_out is valid.
- addr_ready  in  1  consumer accepts addr_out.
- addr_last  out  1  addr_out is the final address of the run.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - All counters and accumulators = 0.
  - addr_out=0, addr_valid=0, addr_last=0, busy=0, done=0.
  - rst has priority over start and abort in the same cycle, and is effective from any state, including mid-run.
- States: IDLE, RUN. done is a registered pulse; there is no separate state for it.
- IDLE:
  - done=0, except in the single cycle directly after the final transfer.
  - On start=1: latch cfg_offset, cfg_extent and cfg_stride; zero all counters.
  - Next cycle: state=RUN, busy=1, addr_valid=1, addr_out=cfg_offset.
  - Latency from start to first valid address = 1 cycle.
- RUN:
  - A transfer occurs on any cycle with addr_valid & addr_ready.
  - Without a transfer, addr_out, addr_last and all counters hold stable. No bubbles are inserted.
  - On a transfer, advance the counters as an odometer:
    - count[0]++.
    - If count[d] == ext[d]-1, set count[d]=0 and carry into d+1.
  - New addr_out is registered at the same edge, so back-to-back transfers give 1 address per cycle.
- Address arithmetic:
  - Multiply-free. Keep acc[d] = count[d]*stride[d].
  - On increment, acc[d] += stride[d]; on wrap, acc[d] = 0.
  - addr_out = offset + sum(acc[d]), all truncated to WIDTH (modulo 2^WIDTH, no saturation, no overflow flag).
- addr_last = 1 exactly when every count[d] == ext[d]-1 (the final tuple of the nest).
- Final transfer (transfer while addr_last=1):
  - Next cycle: state=IDLE, addr_valid=0, addr_last=0, busy=0, done=1 for exactly one cycle.
  - addr_out holds its last value.
- Extent 0 in any dimension is treated as extent 1 (that dimension stays at 0). Total transfers = product of effective extents.
- All-ones nest (every extent 1): a single address equal to offset, with addr_last=1 on it.
- start in RUN is ignored. Configuration inputs changing during RUN have no effect.
- start in the same cycle that done=1 (back in IDLE) is accepted normally.
- abort=1 in RUN:
  - Next cycle: IDLE, addr_valid=0, busy=0, done=0, counters 0.
  - abort together with a final transfer still suppresses done.
  - abort in IDLE is a no-op, and it takes priority over start in the same cycle.
- Stride 0 is legal: the same address repeats for that dimension.

Test Plan:
- 2D nest, DIMS=2, ext={3,2}, stride={1,10}, offset=100, ready held 1:
  - addresses 100,101,102,110,111,112 on 6 consecutive cycles;
  - addr_last only on 112;
  - done pulses 1 cycle later; busy falls with it.
- Same config, ready toggled 1,0,0,1,...:
  - addr_out and addr_last stable while ready=0;
  - same 6-address sequence, no duplicates or skips.
- DIMS=3, ext={2,0,2}, stride={4,7,100}, offset=0:
  - dimension 1 behaves as extent 1;
  - sequence 0,4,100,104; done after 4 transfers.
- Wrap: WIDTH=16, offset=16'hFFFE, ext={4,1,1}, stride={1,0,0}:
  - addresses FFFE,FFFF,0000,0001.
- Abort and reset mid-run:
  - abort after 2 transfers → IDLE next cycle, no done pulse;
  - a fresh start gives first address = offset;
  - rst asserted alongside start → outputs stay at reset values.
- start pulsed during RUN and cfg_stride changed mid-run:
  - sequence unaffected;
  - start on the done cycle launches a new run with the new config.
